// File: rtl/lsu_sram_ctrl.sv
// LSU-to-SRAM access controller: IDLE -> ACCESS (1+WAIT_CYCLES) -> DONE with lane/byte-enable generation.
// Optional misalignment checking is enabled with macro SRAM_MISALIGN_CHK_EN.
module lsu_sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wren,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_st_data,
    output logic        o_ready,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rd_data,
    output logic [10:0] o_sram_addr,
    output logic        o_sram_ce,
    output logic        o_sram_we,
    output logic [3:0]  o_sram_be,
    output logic [31:0] o_sram_wdata,
    input  logic [31:0] i_sram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wren_q, wren_d;
    logic        err_q, err_d;
    logic [3:0]  be_q, be_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        accept;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        misalign;

    assign accept = i_req && (state_q == IDLE) && (i_addr[15:13] == 3'b001);

    // size=11 falls into the word lanes; the checker (if built) rejects it first
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_st_data;
        case (i_size)
            2'b00: begin
                be_new    = 4'b0001 << i_addr[1:0];
                wdata_new = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{i_st_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = i_st_data;
            end
        endcase
    end

`ifdef SRAM_MISALIGN_CHK_EN
    assign misalign = ((i_size == 2'b01) && i_addr[0]) ||
                      ((i_size == 2'b10) && (i_addr[1:0] != 2'b00)) ||
                      (i_size == 2'b11);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wren_d    = wren_q;
        err_d     = err_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wren_d  = i_wren;
                    be_d    = be_new;
                    addr_d  = i_addr[12:2];
                    wdata_d = wdata_new;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 3'(WAIT_CYCLES);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    if (!wren_q)
                        rd_data_d = i_sram_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            wren_q    <= 1'b0;
            err_q     <= 1'b0;
            be_q      <= 4'd0;
            addr_q    <= 11'd0;
            wdata_q   <= 32'd0;
            rd_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wren_q    <= wren_d;
            err_q     <= err_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    // SRAM strobes are pure state decodes so reset drops them without waiting for a clock
    assign o_ready      = (state_q == IDLE);
    assign o_ack        = (state_q == DONE);
`ifdef SRAM_MISALIGN_CHK_EN
    assign o_err        = (state_q == DONE) && err_q;
`else
    assign o_err        = 1'b0;
`endif
    assign o_sram_ce    = (state_q == ACCESS);
    assign o_sram_we    = (state_q == ACCESS) && wren_q;
    assign o_sram_be    = (state_q == ACCESS) ? be_q : 4'd0;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_rd_data    = rd_data_q;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench for lsu_sram_ctrl (WAIT_CYCLES=1); expected values are hand-computed.
module tb_lsu_sram_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        i_wren;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic [31:0] i_st_data;
    logic        o_ready;
    logic        o_ack;
    logic        o_err;
    logic [31:0] o_rd_data;
    logic [10:0] o_sram_addr;
    logic        o_sram_ce;
    logic        o_sram_we;
    logic [3:0]  o_sram_be;
    logic [31:0] o_sram_wdata;
    logic [31:0] i_sram_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    lsu_sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_wren       (i_wren),
        .i_addr       (i_addr),
        .i_size       (i_size),
        .i_st_data    (i_st_data),
        .o_ready      (o_ready),
        .o_ack        (o_ack),
        .o_err        (o_err),
        .o_rd_data    (o_rd_data),
        .o_sram_addr  (o_sram_addr),
        .o_sram_ce    (o_sram_ce),
        .o_sram_we    (o_sram_we),
        .o_sram_be    (o_sram_be),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_chk++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        i_req     = 1'b1;
        i_wren    = wr;
        i_addr    = a;
        i_size    = sz;
        i_st_data = d;
        tick();
        i_req     = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_wren = 1'b0; i_addr = '0;
        i_size = 2'b00; i_st_data = '0; i_sram_rdata = '0;
        #12;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_ce",    {31'd0, o_sram_ce}, 32'd0);
        chk("rst_ack",   {31'd0, o_ack}, 32'd0);
        chk("rst_rd",    o_rd_data, 32'd0);
        chk("rst_addr",  {21'd0, o_sram_addr}, 32'd0);
        chk("rst_wdata", o_sram_wdata, 32'd0);
        i_rst = 1'b0;
        tick();

        // word store 0xDEADBEEF @0x2004; inputs scrambled after accept
        issue(1'b1, 32'h2004, 2'b10, 32'hDEADBEEF);
        i_addr = 32'h2FFC; i_st_data = 32'h0; i_wren = 1'b0;
        chk("st_t1_ce",    {31'd0, o_sram_ce}, 32'd1);
        chk("st_t1_we",    {31'd0, o_sram_we}, 32'd1);
        chk("st_t1_be",    {28'd0, o_sram_be}, 32'hF);
        chk("st_t1_addr",  {21'd0, o_sram_addr}, 32'd1);
        chk("st_t1_wdata", o_sram_wdata, 32'hDEADBEEF);
        chk("st_t1_ready", {31'd0, o_ready}, 32'd0);
        tick();
        chk("st_t2_ce",    {31'd0, o_sram_ce}, 32'd1);
        chk("st_t2_we",    {31'd0, o_sram_we}, 32'd1);
        chk("st_t2_ack",   {31'd0, o_ack}, 32'd0);
        tick();
        chk("st_t3_ack",   {31'd0, o_ack}, 32'd1);
        chk("st_t3_ce",    {31'd0, o_sram_ce}, 32'd0);
        chk("st_t3_be",    {28'd0, o_sram_be}, 32'd0);
        chk("st_t3_rd",    o_rd_data, 32'd0);
        tick();
        chk("st_t4_ack",   {31'd0, o_ack}, 32'd0);
        chk("st_t4_ready", {31'd0, o_ready}, 32'd1);

        // word load @0x2004, SRAM returns 0xDEADBEEF
        i_sram_rdata = 32'hDEADBEEF;
        issue(1'b0, 32'h2004, 2'b10, 32'h0);
        chk("ld_t1_ce", {31'd0, o_sram_ce}, 32'd1);
        chk("ld_t1_we", {31'd0, o_sram_we}, 32'd0);
        tick();
        chk("ld_t2_rd", o_rd_data, 32'd0);
        tick();
        i_sram_rdata = 32'h12345678;
        chk("ld_t3_ack", {31'd0, o_ack}, 32'd1);
        chk("ld_t3_rd",  o_rd_data, 32'hDEADBEEF);
        tick();
        tick();
        chk("ld_hold_rd", o_rd_data, 32'hDEADBEEF);

        // byte store 0xA5 @0x2003
        issue(1'b1, 32'h2003, 2'b00, 32'h000000A5);
        chk("sb_be",    {28'd0, o_sram_be}, 32'h8);
        chk("sb_wdata", o_sram_wdata, 32'hA5A5A5A5);
        chk("sb_addr",  {21'd0, o_sram_addr}, 32'd0);
        tick(); tick(); tick();
        chk("sb_rd_hold", o_rd_data, 32'hDEADBEEF);

        // half store 0x1234 @0x2002
        issue(1'b1, 32'h2002, 2'b01, 32'hFFFF1234);
        chk("sh_be",    {28'd0, o_sram_be}, 32'hC);
        chk("sh_wdata", o_sram_wdata, 32'h12341234);
        tick(); tick(); tick();

        // byte store @0x2001 -> lane 1
        issue(1'b1, 32'h2001, 2'b00, 32'h0000003C);
        chk("sb1_be", {28'd0, o_sram_be}, 32'h2);
        tick(); tick(); tick();

        // outside the SRAM window
        issue(1'b1, 32'h7800, 2'b10, 32'h11111111);
        chk("oow_ce",    {31'd0, o_sram_ce}, 32'd0);
        chk("oow_ready", {31'd0, o_ready}, 32'd1);
        chk("oow_ack",   {31'd0, o_ack}, 32'd0);
        tick();
        chk("oow_ack2",  {31'd0, o_ack}, 32'd0);

        // reset at T+1 of a load
        i_sram_rdata = 32'h55555555;
        issue(1'b0, 32'h2008, 2'b10, 32'h0);
        chk("rl_t1_ce", {31'd0, o_sram_ce}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("rl_ce",    {31'd0, o_sram_ce}, 32'd0);
        chk("rl_ack",   {31'd0, o_ack}, 32'd0);
        chk("rl_rd",    o_rd_data, 32'd0);
        chk("rl_ready", {31'd0, o_ready}, 32'd1);
        tick();
        i_rst = 1'b0;
        tick();
        chk("rl_ack2", {31'd0, o_ack}, 32'd0);
        chk("rl_rd2",  o_rd_data, 32'd0);

        // misaligned word load @0x2002
        i_sram_rdata = 32'hCAFEF00D;
        issue(1'b0, 32'h2002, 2'b10, 32'h0);
`ifdef SRAM_MISALIGN_CHK_EN
        chk("mis_ack", {31'd0, o_ack}, 32'd1);
        chk("mis_err", {31'd0, o_err}, 32'd1);
        chk("mis_ce",  {31'd0, o_sram_ce}, 32'd0);
        chk("mis_rd",  o_rd_data, 32'd0);
        tick();
        chk("mis_ready", {31'd0, o_ready}, 32'd1);
        chk("mis_err2",  {31'd0, o_err}, 32'd0);
`else
        chk("mis_be",  {28'd0, o_sram_be}, 32'hF);
        chk("mis_ce",  {31'd0, o_sram_ce}, 32'd1);
        chk("mis_err", {31'd0, o_err}, 32'd0);
        tick(); tick();
        chk("mis_ack",  {31'd0, o_ack}, 32'd1);
        chk("mis_err2", {31'd0, o_err}, 32'd0);
        chk("mis_rd",   o_rd_data, 32'hCAFEF00D);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_sram_ctrl.md
LSU_SRAM_CTRL -- requirements
Module: lsu_sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, range 0..7: extra SRAM access cycles beyond the first.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_req, input, 1: LSU access request.
REQ-005 SHALL have port i_wren, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port i_addr, input, 32: byte address.
REQ-007 SHALL have port i_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 SHALL have port i_st_data, input, 32: store data, right-aligned.
REQ-009 SHALL have port o_ready, output, 1: block idle and able to accept.
REQ-010 SHALL have port o_ack, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port o_err, output, 1: misaligned flag, valid with o_ack.
REQ-012 SHALL have port o_rd_data, output, 32: raw SRAM word to the load-data output mux SRAM input.
REQ-013 SHALL have port o_sram_addr, output, 11: word address, i_addr[12:2].
REQ-014 SHALL have port o_sram_ce, output, 1: SRAM chip enable.
REQ-015 SHALL have port o_sram_we, output, 1: SRAM write enable.
REQ-016 SHALL have port o_sram_be, output, 4: SRAM byte-lane enables.
REQ-017 SHALL have port o_sram_wdata, output, 32: lane-replicated store data.
REQ-018 SHALL have port i_sram_rdata, input, 32: SRAM read word.

Function
REQ-019 SHALL accept a request only when i_req=1, o_ready=1 and i_addr[15:13]=001 (SRAM window); other addresses are ignored and cause no state change.
REQ-020 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; o_ready=1 only in IDLE.
REQ-021 SHALL register addr, size, wren and data at acceptance (cycle T), so later input changes have no effect.
REQ-022 SHALL stay in ACCESS for cycles T+1 .. T+1+WAIT_CYCLES, asserting o_sram_ce=1, o_sram_we=wren, and o_sram_be/o_sram_addr/o_sram_wdata from the latched request.
REQ-023 SHALL capture i_sram_rdata into o_rd_data at the end of the last ACCESS cycle for loads only.
REQ-024 SHALL be in DONE at T+2+WAIT_CYCLES with o_ack=1 for exactly that cycle, then return to IDLE; the next accept is possible at T+3+WAIT_CYCLES.
REQ-025 SHALL hold o_rd_data unchanged by stores, errors and idle cycles.
REQ-026 SHALL generate byte lanes as follows: byte -> be = 0001 shifted left by addr[1:0]; half -> 0011 if addr[1]=0, else 1100; word -> 1111.
REQ-027 SHALL generate o_sram_wdata as follows: byte -> {4{d[7:0]}}; half -> {2{d[15:0]}}; word -> d.
REQ-028 SHALL drive o_sram_ce, o_sram_we and o_sram_be to 0 outside ACCESS.
REQ-029 SHALL use a 3-bit wait counter loaded with WAIT_CYCLES on entry to ACCESS; WAIT_CYCLES=0 gives a single ACCESS cycle.

Reset
REQ-030 SHALL, while i_rst=1 and independent of i_clk, force IDLE, counter 0, o_ack=0, o_err=0, o_rd_data=0, o_sram_ce=0, o_sram_we=0, o_sram_be=0, o_sram_addr=0, o_sram_wdata=0, and o_ready=1.
REQ-031 SHALL, on reset during ACCESS or DONE, abort the access with no o_ack and deassert o_sram_ce/o_sram_we immediately.

Configuration
REQ-032 SHALL, when macro SRAM_MISALIGN_CHK_EN is defined, flag as misaligned any of: half with addr[0]=1, word with addr[1:0]!=00, or size=11; a misaligned accept SHALL go IDLE -> DONE directly (no ACCESS, o_sram_ce stays 0), with o_ack=1, o_err=1 at T+1, and o_rd_data unchanged.
REQ-033 SHALL, when SRAM_MISALIGN_CHK_EN is undefined, tie o_err to 0, treat size=11 as word, ignore address bits below the lane granularity, and omit the check logic.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=1, word store 0xDEADBEEF at 0x2004 -> ce/we=1 at T+1..T+2, be=1111, addr=1, ack at T+3.
REQ-035 SHALL cover: load from 0x2004 with SRAM returning 0xDEADBEEF -> o_rd_data=0xDEADBEEF at T+3 with ack, held afterwards.
REQ-036 SHALL cover: byte store 0x000000A5 at 0x2003 -> be=1000, wdata=0xA5A5A5A5; half store at 0x2002 -> be=1100.
REQ-037 SHALL cover: request at 0x7800 (outside window) -> no ce, no ack, o_ready stays 1.
REQ-038 SHALL cover: i_rst asserted at T+1 of a load -> ce=0 immediately, no ack, o_rd_data=0.
REQ-039 SHALL cover: with SRAM_MISALIGN_CHK_EN defined, word load at 0x2002 -> ack=1, err=1 at T+1, ce never asserted; without the macro, be=1111 and err=0.
